// File: rtl/sr_bank_arbiter_pkg.sv
// Shared types and defaults for the SR-cell bank arbiter: FSM encoding, op encoding and
// default parameter values.
package sr_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDrive   = 2'd1,
    StRecover = 2'd2
  } state_e;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_AW    = 3;
  localparam int unsigned DEF_PULSE = 2;

endpackage

// File: rtl/sr_bank_arbiter_rr_pick.sv
// Round-robin selector: picks the first asserted request at or after the pointer position,
// wrapping modulo NREQ.
module rr_pick
  import sr_bank_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   pointer,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  logic [PW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PW'((32'(pointer) + k) % NREQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_bank_arbiter.sv
// Arbitrates NREQ requesters onto a bank of SR cells with a held S/R pulse and a guard cycle.
// Optional readback checking of the bank Q outputs is enabled by SR_BANK_READBACK_EN.
module sr_bank_arbiter
  import sr_bank_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned PULSE = DEF_PULSE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    op,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic [WIDTH-1:0]   ff_en,
  output logic [WIDTH-1:0]   s_out,
  output logic [WIDTH-1:0]   r_out,
  output logic [WIDTH-1:0]   shadow
`ifdef SR_BANK_READBACK_EN
  ,
  input  logic [WIDTH-1:0]   q_in,
  output logic               err
`endif
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  win_q, win_d;
  logic             op_q, op_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;

  logic [NREQ-1:0]  pick;
  logic             pick_valid;
  logic             pick_op;
  logic [AW-1:0]    pick_addr;
  logic [PW-1:0]    pick_idx;
  logic [WIDTH-1:0] sel;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req     (req),
    .pointer (ptr_q),
    .winner  (pick),
    .valid   (pick_valid)
  );

  always_comb begin
    pick_op   = 1'b0;
    pick_addr = '0;
    pick_idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        pick_op   = op[i];
        pick_addr = addr[i*AW +: AW];
        pick_idx  = PW'(i);
      end
    end
  end

  // Out-of-range addresses decode to no cell, so they never drive or update the bank.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sel[i] = (32'(addr_q) == i);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    op_d     = op_q;
    addr_d   = addr_q;
    shadow_d = shadow_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StDrive;
          cnt_d   = 4'(PULSE - 1);
          win_d   = pick;
          op_d    = pick_op;
          addr_d  = pick_addr;
          ptr_d   = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          state_d = StRecover;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRecover: begin
        state_d  = StIdle;
        shadow_d = (shadow_q & ~sel) | (sel & {WIDTH{op_q}});
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ptr_q    <= '0;
      win_q    <= '0;
      op_q     <= 1'b0;
      addr_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      shadow_q <= shadow_d;
    end
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  assign busy   = (state_q != StIdle);
  assign gnt    = (state_q == StRecover) ? win_q : '0;
  assign ff_en  = (state_q == StDrive) ? sel : '0;
  assign s_out  = (state_q == StDrive && op_q == OP_SET) ? sel : '0;
  assign r_out  = (state_q == StDrive && op_q == OP_CLR) ? sel : '0;
  assign shadow = shadow_q;

`ifdef SR_BANK_READBACK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == StRecover && |(sel & (q_in ^ {WIDTH{op_q}}))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed self-checking bench for sr_bank_arbiter (NREQ=4, WIDTH=6, AW=3, PULSE=2).
module tb_sr_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  op;
  logic [11:0] addr;
  logic [3:0]  gnt;
  logic        busy;
  logic [5:0]  ff_en;
  logic [5:0]  s_out;
  logic [5:0]  r_out;
  logic [5:0]  shadow;
`ifdef SR_BANK_READBACK_EN
  logic [5:0]  q_in = '0;
  logic        err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sr_bank_arbiter #(
    .NREQ  (4),
    .WIDTH (6),
    .AW    (3),
    .PULSE (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .op     (op),
    .addr   (addr),
    .gnt    (gnt),
    .busy   (busy),
    .ff_en  (ff_en),
    .s_out  (s_out),
    .r_out  (r_out),
    .shadow (shadow)
`ifdef SR_BANK_READBACK_EN
    ,
    .q_in   (q_in),
    .err    (err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Issue one request from IDLE and check every cycle through to the updated shadow.
  task automatic do_op(input string tag, input logic [3:0] r, input logic [3:0] o,
                       input logic [11:0] a, input logic [3:0] eg, input logic [5:0] ebit,
                       input logic eop, input logic [5:0] esh);
    req  = r;
    op   = o;
    addr = a;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check({tag, "_drv_ff_en"}, 32'(ff_en), 32'(ebit));
      check({tag, "_drv_s_out"}, 32'(s_out), eop ? 32'(ebit) : 32'd0);
      check({tag, "_drv_r_out"}, 32'(r_out), eop ? 32'd0 : 32'(ebit));
      check({tag, "_drv_s_and_r"}, 32'(s_out & r_out), 32'd0);
      check({tag, "_drv_gnt"}, 32'(gnt), 32'd0);
    end
    tick();
    check({tag, "_rec_gnt"}, 32'(gnt), 32'(eg));
    check({tag, "_rec_drive"}, 32'(ff_en | s_out | r_out), 32'd0);
    check({tag, "_rec_busy"}, 32'(busy), 32'd1);
    req = '0;
    tick();
    check({tag, "_shadow"}, 32'(shadow), 32'(esh));
    check({tag, "_post_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_post_busy"}, 32'(busy), 32'd0);
  endtask

  // Bounded wait for the next grant; reports which requester and how many cycles it took.
  task automatic wait_gnt(input string tag, input logic [3:0] eg, input int ecyc);
    int n = 0;
    do begin
      tick();
      n++;
    end while (gnt == '0 && n < 20);
    check({tag, "_gnt"}, 32'(gnt), 32'(eg));
    check({tag, "_cycles"}, 32'(n), 32'(ecyc));
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    op   = '0;
    addr = '0;
    #2;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drive", 32'(ff_en | s_out | r_out), 32'd0);
    check("rst_shadow", 32'(shadow), 32'd0);
    tick();
    rst = 1'b0;

    // Single set of cell 5 from requester 0.
    do_op("set5", 4'b0001, 4'b0001, 12'd5, 4'b0001, 6'h20, 1'b1, 6'h20);

    // Full contention after reset: grants 0,1,2,3 with one grant every 4 cycles.
    do_reset();
    req  = 4'b1111;
    op   = 4'b1111;
    addr = {3'd3, 3'd2, 3'd1, 3'd0};
    wait_gnt("cont0", 4'b0001, 3);
    wait_gnt("cont1", 4'b0010, 4);
    wait_gnt("cont2", 4'b0100, 4);
    wait_gnt("cont3", 4'b1000, 4);
    req = '0;
    tick();
    check("cont_shadow", 32'(shadow), 32'h0f);

    // Fairness: last winner 2, then 0 and 2 both request -> 0 first, then 2.
    do_reset();
    req  = 4'b0100;
    op   = 4'b0101;
    addr = {3'd0, 3'd4, 3'd0, 3'd1};
    wait_gnt("rr_a", 4'b0100, 3);
    req = 4'b0101;
    wait_gnt("rr_b", 4'b0001, 4);
    wait_gnt("rr_c", 4'b0100, 4);
    req = '0;
    tick();
    check("rr_shadow", 32'(shadow), 32'h12);

    // Set then clear cell 3, then an out-of-range address.
    do_op("set3", 4'b0001, 4'b0001, 12'd3, 4'b0001, 6'h08, 1'b1, 6'h1a);
    do_op("clr3", 4'b0001, 4'b0000, 12'd3, 4'b0001, 6'h08, 1'b0, 6'h12);
    do_op("bad6", 4'b0001, 4'b0001, 12'd6, 4'b0001, 6'h00, 1'b1, 6'h12);

    // Reset in the first DRIVE cycle discards the operation; the held request then completes.
    req  = 4'b0001;
    op   = 4'b0001;
    addr = 12'd2;
    tick();
    check("mid_drive_ff_en", 32'(ff_en), 32'h04);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_drive", 32'(ff_en | s_out | r_out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_shadow", 32'(shadow), 32'd0);
    tick();
    check("mid_rst_edge_gnt", 32'(gnt), 32'd0);
    rst = 1'b0;
    wait_gnt("after_rst", 4'b0001, 3);
    req = '0;
    tick();
    check("after_rst_shadow", 32'(shadow), 32'h04);

`ifdef SR_BANK_READBACK_EN
    // Bank Q tied low: setting cell 1 must raise the sticky error flag.
    do_reset();
    check("rb_err_reset", 32'(err), 32'd0);
    do_op("rb_set1", 4'b0001, 4'b0001, 12'd1, 4'b0001, 6'h02, 1'b1, 6'h02);
    check("rb_err_set", 32'(err), 32'd1);
    tick();
    tick();
    check("rb_err_sticky", 32'(err), 32'd1);
    do_reset();
    check("rb_err_cleared", 32'(err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
